// File: rtl/servo_pulse_gen_if.sv
// servo_pulse_gen_if: control and output bundle for servo_pulse_gen.
//   enable      run frames when high
//   wr_en       width write strobe, one cycle per write
//   wr_chan     target channel of the write
//   wr_width    new pulse width in sys_clk cycles
//   pulse       registered per-channel pulse outputs
//   frame_start one-cycle strobe at phase 0 of channel 0
// master: register-decode side. slave: the pulse generator.
interface servo_pulse_gen_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 19,
  parameter int unsigned CH_W     = 1
) ();
  logic                enable;
  logic                wr_en;
  logic [CH_W-1:0]     wr_chan;
  logic [CNT_W-1:0]    wr_width;
  logic [CHANNELS-1:0] pulse;
  logic                frame_start;

  modport master (
    output enable, wr_en, wr_chan, wr_width,
    input  pulse, frame_start
  );

  modport slave (
    input  enable, wr_en, wr_chan, wr_width,
    output pulse, frame_start
  );
endinterface

// File: rtl/servo_pulse_gen.sv
// servo_pulse_gen: multi-channel periodic pulse generator (servos, sonar strobes).
// A shared frame counter runs 0..PERIOD-1 while enabled. Each channel has a
// double-buffered width: writes land in shadow, and active picks shadow up at
// the channel's last phase (or every cycle while disabled), so a new width
// never cuts a pulse short.
// Ports:
//   sys_clk  clock
//   rst      asynchronous active-high reset
//   bus      servo_pulse_gen_if slave (enable, wr_en/wr_chan/wr_width in;
//            pulse/frame_start out, both registered)
// Optional feature: define SERVO_PULSE_GEN_STAGGER_EN to offset channel c by
// c*(PERIOD/CHANNELS) cycles so channels do not rise together.
module servo_pulse_gen #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned PERIOD     = 500000,
  parameter int unsigned CNT_W      = 19,
  parameter int unsigned DEFAULT_PW = 75000,
  parameter int unsigned CH_W       = 1
) (
  input logic                sys_clk,
  input logic                rst,
  servo_pulse_gen_if.slave   bus
);

  localparam logic [CNT_W-1:0] PerW   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LastW  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] RstPw  = (DEFAULT_PW > PERIOD) ? PerW : CNT_W'(DEFAULT_PW);
`ifdef SERVO_PULSE_GEN_STAGGER_EN
  localparam int unsigned      Step   = PERIOD / CHANNELS;
`endif

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    shadow_q [CHANNELS];
  logic [CNT_W-1:0]    shadow_d [CHANNELS];
  logic [CNT_W-1:0]    active_q [CHANNELS];
  logic [CNT_W-1:0]    active_d [CHANNELS];
  logic [CNT_W-1:0]    ph       [CHANNELS];
  logic [CNT_W-1:0]    wr_clamped;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic                frame_start_q, frame_start_d;

  always_comb begin
    wr_clamped    = (bus.wr_width > PerW) ? PerW : bus.wr_width;
    cnt_d         = '0;
    if (bus.enable) begin
      cnt_d = (cnt_q == LastW) ? '0 : cnt_q + CNT_W'(1);
    end
    frame_start_d = bus.enable && (cnt_q == '0);
    pulse_d       = '0;

    for (int c = 0; c < CHANNELS; c++) begin
`ifdef SERVO_PULSE_GEN_STAGGER_EN
      // (cnt - off) mod PERIOD without a divider; off < PERIOD always.
      if (cnt_q >= CNT_W'(c * Step)) begin
        ph[c] = cnt_q - CNT_W'(c * Step);
      end else begin
        ph[c] = cnt_q + (PerW - CNT_W'(c * Step));
      end
`else
      ph[c] = cnt_q;
`endif
      // Out-of-range wr_chan matches no channel, so the write is dropped.
      shadow_d[c] = (bus.wr_en && (bus.wr_chan == CH_W'(c))) ? wr_clamped : shadow_q[c];
      // shadow_d carries the same-cycle write, giving the copy-point bypass.
      active_d[c] = (!bus.enable || (ph[c] == LastW)) ? shadow_d[c] : active_q[c];
      pulse_d[c]  = bus.enable && (ph[c] < active_q[c]);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      pulse_q       <= '0;
      frame_start_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        shadow_q[c] <= RstPw;
        active_q[c] <= RstPw;
      end
    end else begin
      cnt_q         <= cnt_d;
      pulse_q       <= pulse_d;
      frame_start_q <= frame_start_d;
      for (int c = 0; c < CHANNELS; c++) begin
        shadow_q[c] <= shadow_d[c];
        active_q[c] <= active_d[c];
      end
    end
  end

  assign bus.pulse       = pulse_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pulse_gen.sv
// tb_servo_pulse_gen: directed bench for servo_pulse_gen with CHANNELS=3,
// PERIOD=20, CNT_W=5, DEFAULT_PW=6, CH_W=2. Expected pulse patterns are
// per-frame 20-bit masks (bit i = level after the edge that saw cnt == i).
module tb_servo_pulse_gen;
  localparam int unsigned CHANNELS = 3;
  localparam int unsigned PERIOD   = 20;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned DEF_PW   = 6;
  localparam int unsigned CH_W     = 2;

  logic sys_clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  servo_pulse_gen_if #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

  servo_pulse_gen #(
    .CHANNELS  (CHANNELS),
    .PERIOD    (PERIOD),
    .CNT_W     (CNT_W),
    .DEFAULT_PW(DEF_PW),
    .CH_W      (CH_W)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [19:0] wmask(input int w);
    logic [31:0] t;
    t = (32'd1 << w) - 32'd1;
    return t[19:0];
  endfunction

  // Runs n edges starting at cnt == 0, optionally writing at cnt == wr_at.
  task automatic run_frame(input string tag, input int n,
                           input logic [19:0] m0, input logic [19:0] m1, input logic [19:0] m2,
                           input int wr_at, input int wr_c, input int wr_w);
    logic [2:0]  exp;
    logic [31:0] wc;
    logic [31:0] ww;
    wc = wr_c;
    ww = wr_w;
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin
        bus.wr_en    = 1'b1;
        bus.wr_chan  = wc[CH_W-1:0];
        bus.wr_width = ww[CNT_W-1:0];
      end
      tick();
      bus.wr_en = 1'b0;
      exp = {m2[i], m1[i], m0[i]};
      chk($sformatf("%s_pulse_cnt%0d", tag, i), 32'(bus.pulse), 32'(exp));
      chk($sformatf("%s_fs_cnt%0d", tag, i), 32'(bus.frame_start), 32'(i == 0));
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.enable   = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_chan  = '0;
    bus.wr_width = '0;

    // Reset state
    tick();
    tick();
    chk("rst_pulse", 32'(bus.pulse), 32'd0);
    chk("rst_fs", 32'(bus.frame_start), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_pulse", 32'(bus.pulse), 32'd0);
    chk("idle_fs", 32'(bus.frame_start), 32'd0);
    bus.enable = 1'b1;

`ifdef SERVO_PULSE_GEN_STAGGER_EN
    // Offsets 0/6/12, default width 6.
    run_frame("stg0", 20, 20'h0003F, 20'h00FC0, 20'h3F000, -1, 0, 0);
    // ch2 = 10 written at cnt 0; ch2 copies at its own last phase (cnt 11).
    run_frame("stg1", 20, 20'h0003F, 20'h00FC0, 20'hFF000, 0, 2, 10);
    run_frame("stg2", 20, 20'h0003F, 20'h00FC0, 20'hFF003, -1, 0, 0);
    run_frame("stg3", 20, 20'h0003F, 20'h00FC0, 20'hFF003, -1, 0, 0);
`else
    // Defaults
    run_frame("def0", 20, wmask(6), wmask(6), wmask(6), -1, 0, 0);
    run_frame("def1", 20, wmask(6), wmask(6), wmask(6), -1, 0, 0);
    // Mid-frame write ch1 = 10 at cnt 5
    run_frame("mid0", 20, wmask(6), wmask(6), wmask(6), 5, 1, 10);
    run_frame("mid1", 20, wmask(6), wmask(10), wmask(6), -1, 0, 0);
    // Copy-cycle bypass: ch2 = 3 at cnt 19
    run_frame("byp0", 20, wmask(6), wmask(10), wmask(6), 19, 2, 3);
    // Out-of-range channel write is ignored
    run_frame("oor0", 20, wmask(6), wmask(10), wmask(3), 7, 3, 9);
    run_frame("oor1", 20, wmask(6), wmask(10), wmask(3), 4, 0, 0);
    // Width limits: ch0 = 0, then ch1 = 25 clamps to 20
    run_frame("lim0", 20, wmask(0), wmask(10), wmask(3), 4, 1, 25);
    run_frame("lim1", 20, wmask(0), wmask(20), wmask(3), -1, 0, 0);
    run_frame("lim2", 20, wmask(0), wmask(20), wmask(3), -1, 0, 0);

    // Drop enable before the cnt 4 edge
    run_frame("drop", 4, wmask(0), wmask(20), wmask(3), -1, 0, 0);
    bus.enable = 1'b0;
    tick();
    chk("dis_pulse0", 32'(bus.pulse), 32'd0);
    chk("dis_fs0", 32'(bus.frame_start), 32'd0);
    bus.wr_en    = 1'b1;
    bus.wr_chan  = 2'd0;
    bus.wr_width = 5'd8;
    tick();
    bus.wr_en = 1'b0;
    chk("dis_pulse1", 32'(bus.pulse), 32'd0);
    tick();
    chk("dis_pulse2", 32'(bus.pulse), 32'd0);
    chk("dis_fs2", 32'(bus.frame_start), 32'd0);
    bus.enable = 1'b1;
    run_frame("reen", 20, wmask(8), wmask(20), wmask(3), -1, 0, 0);

    // Asynchronous reset mid-pulse
    run_frame("prerst", 3, wmask(8), wmask(20), wmask(3), -1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pulse", 32'(bus.pulse), 32'd0);
    chk("arst_fs", 32'(bus.frame_start), 32'd0);
    tick();
    chk("arst_hold_pulse", 32'(bus.pulse), 32'd0);
    rst = 1'b0;
    run_frame("postrst", 20, wmask(6), wmask(6), wmask(6), -1, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
